tt_adder_rr_sched: RTL and testbench
====================================

Name: tt_adder_rr_sched

Overview:
- Round-robin scheduler that shares one combinational WIDTH-bit adder (the ui_in + uio_in style datapath) between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one requester per cycle and steers its operands onto the shared adder.
- The sum, the carry and the winning requester ID are registered into a single-entry response slot with its own valid/ready handshake.
- Sits between the top-level pin mux (or on-chip requesters) and the shared adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and sum width.
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- req_valid  in  NUM_REQ  per-requester operand-valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing as req_a.
- add_a  out  WIDTH  operand A steered to the shared adder.
- add_b  out  WIDTH  operand B steered to the shared adder.
- add_sum  in  WIDTH+1  combinational result {carry, sum} returned from the shared adder.
- rsp_valid  out  1  response slot occupied.
- rsp_ready  in  1  consumer accepts the response.
- rsp_sum  out  WIDTH  registered sum.
- rsp_carry  out  1  registered carry-out.
- rsp_id  out  clog2(NUM_REQ)  index of the requester that produced the response.
- txn_count  out  CNT_W  number of accepted transactions since reset.

Behaviour:
- Reset values (synchronous, rst=1 at the edge): rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, txn_count=0, priority pointer ptr=0.
  - While rst=1, req_ready is all-zero regardless of the other inputs.
- Slot-free condition: can_accept = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit is the winner g.
  - gnt_any = can_accept && |req_valid.
- Outputs of arbitration:
  - req_ready = one-hot(g) when gnt_any, else 0.
  - add_a/add_b = operands of g when gnt_any, else 0 (zero-forced to keep adder toggling low).
- On a clock edge with gnt_any:
  - rsp_sum <= add_sum[WIDTH-1:0], rsp_carry <= add_sum[WIDTH], rsp_id <= g, rsp_valid <= 1.
  - ptr <= (g+1) mod NUM_REQ.
  - txn_count <= txn_count+1, wrapping from all-ones to 0.
- On a clock edge with rsp_valid && rsp_ready && !gnt_any: rsp_valid <= 0; the other rsp_* fields hold.
- Simultaneous drain and accept (rsp_ready=1, new grant): the new result replaces the old one in the same edge.
  - rsp_valid stays 1; back-to-back throughput is 1 transaction per cycle.
- Stall (rsp_valid=1, rsp_ready=0):
  - req_ready=0, ptr and txn_count hold.
  - rsp_* must stay stable until accepted.
- Latency: accept edge -> rsp_valid visible 1 cycle later (registered output, combinational adder).
- Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- No grant occurs when req_valid=0; ptr holds.
- Requesters must hold req_a/req_b stable while req_valid=1 and req_ready=0. The scheduler does not latch operands before grant.
- Reset mid-stall: a pending response is discarded, rsp_valid=0 next cycle, no req_ready asserted in the reset cycle.
- Control FSM, two states:
  - EMPTY (rsp_valid=0): goes to FULL on gnt_any.
  - FULL (rsp_valid=1): stays in FULL on a new grant or on a stall; goes to EMPTY on rsp_ready with no new grant.

Decomposition:
- Package tt_adder_pkg: ID_W = clog2(NUM_REQ) helper function and the state enum {EMPTY, FULL}.
- Sub-module tt_rr_arbiter (req vector, ptr in -> one-hot grant, index, any): pure combinational, reusable.
- Top module holds ptr, the response slot and the counter.

Test Plan:
- Reset: assert rst for 2 cycles with all req_valid=1 -> req_ready=0 during reset; afterwards rsp_valid=0, txn_count=0.
- Single add: req 2 presents a=0xF0, b=0x20, rsp_ready=1 -> req_ready[2]=1 in that cycle; next cycle rsp_valid=1, rsp_sum=0x10, rsp_carry=1, rsp_id=2, txn_count=1.
- Round robin: all 4 requesters valid continuously, rsp_ready=1, 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3, one response per cycle, txn_count=8.
- Stall: rsp_ready=0 after the first response with all requesters valid for 5 cycles -> req_ready=0 and rsp_* frozen. On release, the next grant goes to ptr and a back-to-back update occurs.
- Sparse requests: only req 1 and req 3 valid with ptr=2 -> grant 3, then 1, then 3; the idle gap does not move ptr.
- Counter wrap: CNT_W=4, 17 transactions -> txn_count reads 0x1 after the 17th. A reset with rsp_valid=1 and rsp_ready=0 clears rsp_valid next cycle.

Source files
------------

// File: rtl/tt_adder_pkg.sv
// rtl/tt_adder_pkg.sv - shared types and helpers for the round-robin adder scheduler
package tt_adder_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tt_adder_rr_sched_if.sv
// rtl/tt_adder_rr_sched_if.sv - requester and response handshake bundle
interface tt_adder_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = tt_adder_pkg::id_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_carry;
  logic [ID_W-1:0]          rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
  );
endinterface

// File: rtl/tt_rr_arbiter.sv
// rtl/tt_rr_arbiter.sv - combinational round-robin arbiter starting its search at ptr
module tt_rr_arbiter import tt_adder_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  int pos;

  // Walk from farthest to nearest so the requester closest to ptr wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    pos = 0;
    any = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = pos[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/tt_adder_rr_sched.sv
// rtl/tt_adder_rr_sched.sv - shares one adder among NUM_REQ requesters via round-robin grant
module tt_adder_rr_sched import tt_adder_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  tt_adder_rr_sched_if.slave  bus,
  output logic [WIDTH-1:0]    add_a,
  output logic [WIDTH-1:0]    add_b,
  input  logic [WIDTH:0]      add_sum,
  output logic [CNT_W-1:0]    txn_count
);
  localparam int ID_W = id_width(NUM_REQ);

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               gnt_found;
  logic               can_accept;
  logic               gnt_any;
  logic [WIDTH-1:0]   rsp_sum_q;
  logic               rsp_carry_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [CNT_W-1:0]   cnt_q;

  tt_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt_oh),
    .idx (gnt_idx),
    .any (gnt_found)
  );

  // Gating with rst keeps req_ready low even before state is initialised.
  assign can_accept = (state == EMPTY) || bus.rsp_ready;
  assign gnt_any    = can_accept && gnt_found && !rst;

  assign bus.req_ready = gnt_any ? gnt_oh : '0;
  assign add_a = gnt_any ? bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH] : '0;
  assign add_b = gnt_any ? bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH] : '0;

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_id    = rsp_id_q;
  assign txn_count     = cnt_q;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (gnt_any) state_nxt = FULL;
      FULL:    if (!gnt_any && bus.rsp_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      ptr         <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_any) begin
        rsp_sum_q   <= add_sum[WIDTH-1:0];
        rsp_carry_q <= add_sum[WIDTH];
        rsp_id_q    <= gnt_idx;
        ptr         <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        cnt_q       <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tt_adder_rr_sched.sv
// tb/tb_tt_adder_rr_sched.sv - directed bench for the round-robin adder scheduler
module tb_tt_adder_rr_sched;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int CNT_W   = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_sum;
  logic [CNT_W-1:0] txn_count;

  int checks = 0;
  int passed = 0;

  // Per-requester sums for the shared operand set: a={84,03,02,01}, b={90,30,20,10}.
  logic [7:0] rr_sum   [4] = '{8'h11, 8'h22, 8'h33, 8'h14};
  logic       rr_carry [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  tt_adder_rr_sched_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  tt_adder_rr_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .txn_count (txn_count)
  );

  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rr_operands();
    bus.req_a = {8'h84, 8'h03, 8'h02, 8'h01};
    bus.req_b = {8'h90, 8'h30, 8'h20, 8'h10};
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    load_rr_operands();
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready cycle %0d got %b want 0000", c, bus.req_ready);
      else passed++;
    end
    rst = 1'b0;
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid);
    else passed++;
    checks++;
    if (txn_count !== 4'h0) $display("FAIL reset_txn_count got %0d want 0", txn_count);
    else passed++;
  endtask

  task automatic test_single_add();
    bus.req_a[2*WIDTH +: WIDTH] = 8'hF0;
    bus.req_b[2*WIDTH +: WIDTH] = 8'h20;
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) $display("FAIL single_req_ready got %b want 0100", bus.req_ready);
    else passed++;
    checks++;
    if ({add_a, add_b} !== 16'hF020) $display("FAIL single_add_ops got %h want f020", {add_a, add_b});
    else passed++;
    step();
    bus.req_valid = '0;
    checks++;
    if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got %b want 1", bus.rsp_valid);
    else passed++;
    checks++;
    if (bus.rsp_sum !== 8'h10 || bus.rsp_carry !== 1'b1) $display("FAIL single_sum got %b_%h want 1_10", bus.rsp_carry, bus.rsp_sum);
    else passed++;
    checks++;
    if (bus.rsp_id !== 2'd2) $display("FAIL single_id got %0d want 2", bus.rsp_id);
    else passed++;
    checks++;
    if (txn_count !== 4'd1) $display("FAIL single_txn got %0d want 1", txn_count);
    else passed++;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 8'h10) $display("FAIL single_drain got v=%b sum=%h want v=0 sum=10", bus.rsp_valid, bus.rsp_sum);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    reset_dut();
    load_rr_operands();
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      checks++;
      if (bus.req_ready !== exp_rdy) $display("FAIL rr_ready[%0d] got %b want %b", k, bus.req_ready, exp_rdy);
      else passed++;
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(k % 4)) $display("FAIL rr_id[%0d] got v=%b id=%0d want v=1 id=%0d", k, bus.rsp_valid, bus.rsp_id, k % 4);
      else passed++;
      checks++;
      if (bus.rsp_sum !== rr_sum[k % 4] || bus.rsp_carry !== rr_carry[k % 4]) $display("FAIL rr_sum[%0d] got %b_%h want %b_%h", k, bus.rsp_carry, bus.rsp_sum, rr_carry[k % 4], rr_sum[k % 4]);
      else passed++;
      checks++;
      if (txn_count !== 4'(k + 1)) $display("FAIL rr_txn[%0d] got %0d want %0d", k, txn_count, k + 1);
      else passed++;
    end
  endtask

  task automatic test_stall();
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) $display("FAIL stall_ready[%0d] got %b want 0000", c, bus.req_ready);
      else passed++;
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_sum !== 8'h14 || txn_count !== 4'd8)
        $display("FAIL stall_frozen[%0d] got v=%b id=%0d sum=%h txn=%0d want v=1 id=3 sum=14 txn=8", c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, txn_count);
      else passed++;
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) $display("FAIL stall_release_ready got %b want 0001", bus.req_ready);
    else passed++;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 8'h11 || txn_count !== 4'd9)
      $display("FAIL stall_release_rsp got v=%b id=%0d sum=%h txn=%0d want v=1 id=0 sum=11 txn=9", bus.rsp_valid, bus.rsp_id, bus.rsp_sum, txn_count);
    else passed++;
  endtask

  task automatic test_sparse();
    logic [3:0] exp_rdy [3] = '{4'b1000, 4'b0010, 4'b1000};
    logic [1:0] exp_id  [3] = '{2'd3, 2'd1, 2'd3};
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000) $display("FAIL sparse_idle_ready[%0d] got %b want 0000", c, bus.req_ready);
      else passed++;
      step();
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || txn_count !== 4'd10) $display("FAIL sparse_idle got v=%b txn=%0d want v=0 txn=10", bus.rsp_valid, txn_count);
    else passed++;
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== exp_rdy[k]) $display("FAIL sparse_ready[%0d] got %b want %b", k, bus.req_ready, exp_rdy[k]);
      else passed++;
      step();
      checks++;
      if (bus.rsp_id !== exp_id[k] || txn_count !== 4'(11 + k)) $display("FAIL sparse_rsp[%0d] got id=%0d txn=%0d want id=%0d txn=%0d", k, bus.rsp_id, txn_count, exp_id[k], 11 + k);
      else passed++;
    end
  endtask

  task automatic test_counter_wrap();
    reset_dut();
    load_rr_operands();
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k >= 15) begin
        checks++;
        if (txn_count !== 4'(k)) $display("FAIL wrap_txn[%0d] got %0d want %0d", k, txn_count, k % 16);
        else passed++;
      end
    end
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) $display("FAIL stall_reset_ready got %b want 0000", bus.req_ready);
    else passed++;
    step();
    rst = 1'b0;
    bus.req_valid = '0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || txn_count !== 4'd0 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 8'h00 || bus.rsp_carry !== 1'b0)
      $display("FAIL stall_reset_state got v=%b txn=%0d id=%0d sum=%h c=%b want all 0", bus.rsp_valid, txn_count, bus.rsp_id, bus.rsp_sum, bus.rsp_carry);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    test_reset();
    test_single_add();
    test_round_robin();
    test_stall();
    test_sparse();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
